// File: rtl/frame_scheduler.sv
// Double-buffered frame scheduler: clear -> draw -> wait for vsync -> swap, using four-phase handshakes.
// Optional FRAME_SCHEDULER_DROP_COUNT_EN adds a saturating counter of vsync edges missed while rendering.
`timescale 1ns/1ps
module frame_scheduler (
    input  logic        Clk,
    input  logic        Reset_n,
    input  logic        render_en,
    input  logic        vsync,
    output logic        clear_start,
    input  logic        clear_done,
    output logic        draw_start,
    input  logic        draw_done,
    output logic        fb_sel,
    output logic [1:0]  phase,
    output logic [15:0] frame_count,
    output logic [7:0]  drop_count
);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_CLEAR     = 3'd1;
    localparam logic [2:0] S_CLEAR_REL = 3'd2;
    localparam logic [2:0] S_DRAW      = 3'd3;
    localparam logic [2:0] S_DRAW_REL  = 3'd4;
    localparam logic [2:0] S_WAIT_VS   = 3'd5;
    localparam logic [2:0] S_SWAP      = 3'd6;

    logic [2:0]  r_state;
    logic [2:0]  w_state_nxt;
    logic        r_vsync_q;
    logic        w_vs_edge;
    logic        r_fb_sel;
    logic [15:0] r_frame_count;

    assign w_vs_edge = vsync & ~r_vsync_q;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:      if (render_en)   w_state_nxt = S_CLEAR;
            S_CLEAR:     if (clear_done)  w_state_nxt = S_CLEAR_REL;
            S_CLEAR_REL: if (!clear_done) w_state_nxt = S_DRAW;
            S_DRAW:      if (draw_done)   w_state_nxt = S_DRAW_REL;
            S_DRAW_REL:  if (!draw_done)  w_state_nxt = S_WAIT_VS;
            // Only edges seen while already waiting count; one arriving on the entry edge is lost.
            S_WAIT_VS:   if (w_vs_edge)   w_state_nxt = S_SWAP;
            S_SWAP:                       w_state_nxt = S_IDLE;
            default:                      w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            r_state       <= S_IDLE;
            r_vsync_q     <= 1'b0;
            r_fb_sel      <= 1'b0;
            r_frame_count <= 16'd0;
        end else begin
            r_state   <= w_state_nxt;
            r_vsync_q <= vsync;
            if (r_state == S_SWAP) begin
                r_fb_sel      <= ~r_fb_sel;
                r_frame_count <= r_frame_count + 16'd1;
            end
        end
    end

    // Outputs decode purely from the state register.
    assign clear_start = (r_state == S_CLEAR);
    assign draw_start  = (r_state == S_DRAW);
    assign fb_sel      = r_fb_sel;
    assign frame_count = r_frame_count;

    always_comb begin
        phase = 2'd0;
        case (r_state)
            S_CLEAR, S_CLEAR_REL: phase = 2'd1;
            S_DRAW,  S_DRAW_REL:  phase = 2'd2;
            S_WAIT_VS:            phase = 2'd3;
            default:              phase = 2'd0;
        endcase
    end

`ifdef FRAME_SCHEDULER_DROP_COUNT_EN
    logic [7:0] r_drop_count;
    logic       w_rendering;

    assign w_rendering = (r_state == S_CLEAR) || (r_state == S_CLEAR_REL) ||
                         (r_state == S_DRAW)  || (r_state == S_DRAW_REL);

    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            r_drop_count <= 8'd0;
        end else if (w_vs_edge && w_rendering && (r_drop_count != 8'hFF)) begin
            r_drop_count <= r_drop_count + 8'd1;
        end
    end

    assign drop_count = r_drop_count;
`else
    assign drop_count = 8'd0;
`endif

endmodule

// File: tb/tb_frame_scheduler.sv
// Scoreboard bench for frame_scheduler: each started frame pushes its expected swap result, the monitor pops it on swap.
// Drop-count expectations follow FRAME_SCHEDULER_DROP_COUNT_EN.
`timescale 1ns/1ps
module tb_frame_scheduler;

    logic        Clk = 1'b0;
    logic        Reset_n = 1'b0;
    logic        render_en = 1'b0;
    logic        vsync = 1'b0;
    logic        clear_done = 1'b0;
    logic        draw_done = 1'b0;
    logic        clear_start;
    logic        draw_start;
    logic        fb_sel;
    logic [1:0]  phase;
    logic [15:0] frame_count;
    logic [7:0]  drop_count;

    frame_scheduler dut (
        .Clk         (Clk),
        .Reset_n     (Reset_n),
        .render_en   (render_en),
        .vsync       (vsync),
        .clear_start (clear_start),
        .clear_done  (clear_done),
        .draw_start  (draw_start),
        .draw_done   (draw_done),
        .fb_sel      (fb_sel),
        .phase       (phase),
        .frame_count (frame_count),
        .drop_count  (drop_count)
    );

    always #5 Clk = ~Clk;

`ifdef FRAME_SCHEDULER_DROP_COUNT_EN
    localparam int DROP_EN = 1;
`else
    localparam int DROP_EN = 0;
`endif

    typedef struct packed {
        logic        fb;
        logic [15:0] cnt;
    } exp_t;

    exp_t        sbq[$];
    int          n_chk = 0;
    int          n_err = 0;
    int          n_swap = 0;
    int          exp_drop = 0;
    logic        exp_fb = 1'b0;
    logic [15:0] exp_cnt = 16'd0;
    logic        overlap = 1'b0;
    logic [1:0]  ph1 = 2'd0;
    logic [1:0]  ph2 = 2'd0;
    logic [15:0] seq = 16'd0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge Clk);
        #1;
    endtask

    function automatic logic sig(input int sel);
        case (sel)
            0:       return clear_start;
            1:       return draw_start;
            2:       return (phase == 2'd3);
            default: return 1'b0;
        endcase
    endfunction

    task automatic wait_sig(input int sel, input logic val, input string tag);
        int k;
        k = 0;
        while (sig(sel) !== val && k < 300) begin
            step(1);
            k++;
        end
        if (sig(sel) !== val) chk({tag, "_timeout"}, 32'd0, 32'd1);
    endtask

    task automatic do_reset(input int n);
        Reset_n = 1'b0;
        render_en = 1'b0; vsync = 1'b0; clear_done = 1'b0; draw_done = 1'b0;
        step(n);
        sbq.delete();
        exp_fb = 1'b0; exp_cnt = 16'd0; exp_drop = 0; overlap = 1'b0;
        Reset_n = 1'b1;
    endtask

    // mode 0: normal vsync in WAIT_VS; 1: two vsync pulses during DRAW; 2: vsync rises on WAIT_VS entry
    task automatic run_frame(input bit from_idle, input int dc, input int dd, input int mode, input bit keep_en);
        exp_t e;
        int   pre;
        int   k;
        if (from_idle) begin
            render_en = 1'b1;
            step(1);
            chk("lat_clear_start", clear_start, 1);
            chk("lat_phase", phase, 1);
        end
        exp_fb  = ~exp_fb;
        exp_cnt = exp_cnt + 16'd1;
        e.fb = exp_fb; e.cnt = exp_cnt;
        sbq.push_back(e);
        wait_sig(0, 1'b1, "cs_rise");
        if (!keep_en) render_en = 1'b0;
        step(dc);
        clear_done = 1'b1;
        wait_sig(0, 1'b0, "cs_fall");
        step(1);
        clear_done = 1'b0;
        wait_sig(1, 1'b1, "ds_rise");
        if (mode == 1) begin
            step(1); vsync = 1'b1; step(2); vsync = 1'b0;
            step(2); vsync = 1'b1; step(2); vsync = 1'b0;
            step(1);
            chk("no_swap_in_draw", phase, 2);
            exp_drop += 2 * DROP_EN;
            step(dd - 8);
        end else begin
            step(dd);
        end
        draw_done = 1'b1;
        wait_sig(1, 1'b0, "ds_fall");
        step(1);
        draw_done = 1'b0;
        if (mode == 2) begin
            vsync = 1'b1;
            exp_drop += DROP_EN;
            step(1);
            chk("enter_wait_vs", phase, 3);
            step(4);
            chk("early_vs_not_consumed", phase, 3);
            vsync = 1'b0;
            step(2);
        end else begin
            wait_sig(2, 1'b1, "wait_vs");
            clear_done = 1'b1; draw_done = 1'b1;
            step(4);
            chk("hold_wait_vs", phase, 3);
            clear_done = 1'b0; draw_done = 1'b0;
        end
        pre = n_swap;
        vsync = 1'b1;
        step(2);
        vsync = 1'b0;
        k = 0;
        while (n_swap == pre && k < 20) begin
            step(1);
            k++;
        end
        if (n_swap == pre) chk("swap_timeout", 32'd0, 32'd1);
    endtask

    always @(negedge Clk) begin
        exp_t e;
        if (!Reset_n) begin
            ph1 = 2'd0; ph2 = 2'd0; seq = 16'd0;
        end else begin
            if (clear_start && draw_start) overlap = 1'b1;
            if (phase != ph1) seq = {seq[11:0], 2'b00, phase};
            if (ph2 == 2'd3 && ph1 == 2'd0) begin
                if (sbq.size() == 0) begin
                    chk("sb_underflow", 32'd1, 32'd0);
                end else begin
                    e = sbq.pop_front();
                    chk("swap_fb", fb_sel, e.fb);
                    chk("swap_cnt", frame_count, e.cnt);
                    chk("swap_seq", seq, 16'h1230);
                    chk("swap_one_cycle", phase, 0);
                end
                seq = 16'd0;
                n_swap++;
            end
            ph2 = ph1;
            ph1 = phase;
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        do_reset(2);
        chk("rst_clear_start", clear_start, 0);
        chk("rst_draw_start", draw_start, 0);
        chk("rst_fb_sel", fb_sel, 0);
        chk("rst_phase", phase, 0);
        chk("rst_frame_count", frame_count, 0);
        chk("rst_drop_count", drop_count, 0);

        clear_done = 1'b1; draw_done = 1'b1;
        step(3);
        chk("idle_ignore_done", phase, 0);
        clear_done = 1'b0; draw_done = 1'b0;
        step(1);

        run_frame(1'b1, 5, 8, 0, 1'b0);
        step(5);
        chk("idle_hold", phase, 0);
        chk("f1_fb_sel", fb_sel, 1);
        chk("f1_frame_count", frame_count, 1);

        do_reset(1);
        run_frame(1'b1, 3, 4, 0, 1'b1);
        run_frame(1'b0, 2, 5, 0, 1'b1);
        run_frame(1'b0, 4, 3, 0, 1'b0);
        step(5);
        chk("held3_phase", phase, 0);
        chk("held3_fb_sel", fb_sel, 1);
        chk("held3_frame_count", frame_count, 3);
        chk("held3_no_overlap", overlap, 0);

        do_reset(1);
        run_frame(1'b1, 2, 12, 1, 1'b0);
        chk("drop_two", drop_count, exp_drop);
        run_frame(1'b1, 2, 3, 2, 1'b0);
        chk("drop_early", drop_count, exp_drop);
        chk("drop_frames", frame_count, 2);

        do_reset(1);
        force dut.r_frame_count = 16'hFFFF;
        step(1);
        release dut.r_frame_count;
        exp_cnt = 16'hFFFF;
        chk("preload", frame_count, 16'hFFFF);
        run_frame(1'b1, 1, 1, 0, 1'b0);
        chk("wrap", frame_count, 0);

        do_reset(1);
        run_frame(1'b1, 1, 1, 0, 1'b0);
        render_en = 1'b1;
        wait_sig(0, 1'b1, "abort_cs_rise");
        step(1);
        clear_done = 1'b1;
        wait_sig(0, 1'b0, "abort_cs_fall");
        step(1);
        clear_done = 1'b0;
        wait_sig(1, 1'b1, "abort_ds_rise");
        chk("abort_pre_fb", fb_sel, 1);
        Reset_n = 1'b0;
        step(1);
        chk("abort_phase", phase, 0);
        chk("abort_draw_start", draw_start, 0);
        chk("abort_clear_start", clear_start, 0);
        chk("abort_fb_sel", fb_sel, 0);
        chk("abort_frame_count", frame_count, 0);
        step(1);
        chk("abort_hold_idle", phase, 0);
        sbq.delete();
        exp_fb = 1'b0; exp_cnt = 16'd0;
        Reset_n = 1'b1;
        step(1);
        chk("post_reset_clear", clear_start, 1);
        run_frame(1'b0, 2, 2, 0, 1'b0);
        step(3);
        chk("post_reset_fb", fb_sel, 1);
        chk("no_overlap", overlap, 0);
        chk("sb_drained", sbq.size(), 0);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/frame_scheduler.md
FRAME_SCHEDULER -- requirements
Module: frame_scheduler

Interface
REQ-001 SHALL have port Clk  input  1  system clock; all state updates on rising edge.
REQ-002 SHALL have port Reset_n  input  1  one clock; reset is synchronous and active-low.
REQ-003 SHALL have port render_en  input  1  level; permits a new frame to begin from IDLE.
REQ-004 SHALL have port vsync  input  1  display vertical-blank level; only its rising edge is used.
REQ-005 SHALL have port clear_start  output  1  request to frame-clear engine.
REQ-006 SHALL have port clear_done  input  1  completion level from frame-clear engine.
REQ-007 SHALL have port draw_start  output  1  request to rasterizer.
REQ-008 SHALL have port draw_done  input  1  completion level from rasterizer.
REQ-009 SHALL have port fb_sel  output  1  back-buffer index being cleared/drawn; display buffer is its complement.
REQ-010 SHALL have port phase  output  2  0 idle, 1 clear, 2 draw, 3 wait-vsync; framebuffer write-port owner select.
REQ-011 SHALL have port frame_count  output  16  completed-swap counter.
REQ-012 SHALL have port drop_count  output  8  missed-vsync counter.

Function
REQ-013 SHALL implement states IDLE, CLEAR, CLEAR_REL, DRAW, DRAW_REL, WAIT_VS, SWAP.
REQ-014 IDLE: render_en=1 -> CLEAR next cycle; else hold.
REQ-015 CLEAR: clear_start=1; clear_done=1 -> CLEAR_REL.
REQ-016 CLEAR_REL: clear_start=0; clear_done=0 -> DRAW (four-phase handshake; engine returns to its wait state).
REQ-017 DRAW: draw_start=1; draw_done=1 -> DRAW_REL.
REQ-018 DRAW_REL: draw_start=0; draw_done=0 -> WAIT_VS.
REQ-019 WAIT_VS: vsync edge -> SWAP.
REQ-020 SWAP: lasts exactly one cycle; fb_sel toggles and frame_count increments (mod 2^16, 0xFFFF wraps to 0) on the exit edge; -> IDLE.
REQ-021 vsync edge = vsync & ~vsync_q, vsync_q being vsync registered once; edge is visible one cycle after vsync rises.
REQ-022 clear_start, draw_start, phase SHALL decode from the state register only (Moore; no combinational input-to-output path).
REQ-023 Latency: render_en sampled high in IDLE at edge N -> clear_start=1, phase=1 during cycle N+1.
REQ-024 phase=0 in IDLE and SWAP; 1 in CLEAR/CLEAR_REL; 2 in DRAW/DRAW_REL; 3 in WAIT_VS.
REQ-025 clear_start and draw_start SHALL never be high in the same cycle.
REQ-026 render_en falling mid-frame SHALL NOT abort; frame completes through SWAP, then block holds in IDLE.
REQ-027 vsync edge in the same cycle as WAIT_VS entry SHALL NOT be consumed; only edges detected while in WAIT_VS cause SWAP.
REQ-028 clear_done/draw_done high outside their owning states SHALL be ignored.

Reset
REQ-029 Reset_n=0 at a rising edge SHALL force IDLE, vsync_q=0, fb_sel=0, frame_count=0, drop_count=0, clear_start=0, draw_start=0, phase=0, regardless of state or inputs.
REQ-030 Reset mid-operation SHALL abandon the frame with no swap; first permissible CLEAR entry is the edge after Reset_n returns high.

Configuration
REQ-031 Macro FRAME_SCHEDULER_DROP_COUNT_EN defined: drop_count increments (saturating at 255) on each vsync edge detected while in CLEAR, CLEAR_REL, DRAW or DRAW_REL.
REQ-032 Macro FRAME_SCHEDULER_DROP_COUNT_EN undefined: drop_count constant 0, no counter logic; all other behaviour identical.

Verification
REQ-033 Reset_n=0 two cycles, then 1 -> all outputs 0, phase=0.
REQ-034 render_en=1, clear_done asserted 5 cycles after clear_start, draw_done 8 cycles after draw_start, each released one cycle after start drops, vsync pulse later -> phase sequence 1,2,3,0; fb_sel 0->1; frame_count 0->1.
REQ-035 Run 3 frames, render_en held high -> fb_sel ends 1, frame_count=3, clear_start/draw_start never overlap.
REQ-036 With FRAME_SCHEDULER_DROP_COUNT_EN, two vsync pulses during DRAW -> drop_count=2, no swap until next vsync in WAIT_VS; without macro -> drop_count=0.
REQ-037 Preload frame_count=0xFFFF (force) then one frame -> frame_count=0x0000.
REQ-038 Reset_n=0 during DRAW with fb_sel=1 -> next cycle phase=0, draw_start=0, fb_sel=0, frame_count=0.
